// File: rtl/pkg_pipeline.sv
// Shared pipeline types: ID/EX control bundle, ALU op classes and the all-zero bubble.
package pkg_pipeline;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpRsvd  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: stalls PC and IF/ID while a load in EX feeds the instruction in ID.
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use,
  output logic             pc_write,
  output logic             if_id_write
);

  always_comb begin
    // $0 is never a real dependency, so a load to $0 must not stall.
    load_use    = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    pc_write    = !load_use;
    if_id_write = !load_use;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, memory-stall hold
// and saturating bubble/flush event counters.
module id_ex_stage_reg
  import pkg_pipeline::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic [1:0]        id_alu_op,
  input  logic              ex_flush,
  input  logic              hold,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t              ctrl_q, ctrl_d, id_ctrl;
  logic [REG_W-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [DATA_W-1:0]  imm_q, imm_d, pc4_q, pc4_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
  logic               load_use;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  always_comb begin
    id_ctrl = '{
      reg_write:  id_reg_write,
      mem_to_reg: id_mem_to_reg,
      mem_read:   id_mem_read,
      mem_write:  id_mem_write,
      alu_src:    id_alu_src,
      reg_dst:    id_reg_dst,
      branch:     id_branch,
      alu_op:     alu_op_e'(id_alu_op)
    };
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    rdata1_d     = rdata1_q;
    rdata2_d     = rdata2_q;
    imm_d        = imm_q;
    pc4_d        = pc4_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    // Hold outranks flush so a taken branch sitting in EX survives a memory stall.
    if (hold) begin
      ctrl_d = ctrl_q;
    end else if (ex_flush || load_use) begin
      ctrl_d   = BUBBLE;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      pc4_d    = '0;
      if (ex_flush) begin
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ctrl_d   = id_ctrl;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      pc4_d    = id_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= BUBBLE;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      imm_q        <= '0;
      pc4_q        <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
      imm_q        <= imm_d;
      pc4_q        <= pc4_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_rdata1     = rdata1_q;
  assign ex_rdata2     = rdata2_q;
  assign ex_imm        = imm_q;
  assign ex_pc4        = pc4_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_branch     = ctrl_q.branch;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign bubble_cnt    = bubble_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: the driver queues hand-derived expectations,
// two monitors pop them (stall enables before the edge, registered state after it).
module tb_id_ex_stage_reg;

  localparam int unsigned CW   = 4;  // narrow counters so saturation is reachable quickly
  localparam int          KLOAD = 0;
  localparam int          KBUB  = 1;
  localparam int          KHOLD = 2;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic [1:0]  alu_op;
  } stage_t;

  typedef struct {
    stage_t st;
    int     bub;
    int     fl;
  } reg_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  stage_t        id_s;
  logic          id_uses_rt, ex_flush, hold;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [31:0]   ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic          ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic          ex_alu_src, ex_reg_dst, ex_branch;
  logic [1:0]    ex_alu_op;
  logic          pc_write, if_id_write;
  logic [CW-1:0] bubble_cnt, flush_cnt;
  stage_t        obs;

  int            total = 0;
  int            bad = 0;
  stage_t        cur;
  reg_exp_t      rq[$];
  bit            cq[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .DATA_W(32),
    .REG_W (5),
    .CNT_W (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_s.rs),
    .id_rt        (id_s.rt),
    .id_rd        (id_s.rd),
    .id_uses_rt   (id_uses_rt),
    .id_rdata1    (id_s.rdata1),
    .id_rdata2    (id_s.rdata2),
    .id_imm       (id_s.imm),
    .id_pc4       (id_s.pc4),
    .id_reg_write (id_s.reg_write),
    .id_mem_to_reg(id_s.mem_to_reg),
    .id_mem_read  (id_s.mem_read),
    .id_mem_write (id_s.mem_write),
    .id_alu_src   (id_s.alu_src),
    .id_reg_dst   (id_s.reg_dst),
    .id_branch    (id_s.branch),
    .id_alu_op    (id_s.alu_op),
    .ex_flush     (ex_flush),
    .hold         (hold),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_rdata1    (ex_rdata1),
    .ex_rdata2    (ex_rdata2),
    .ex_imm       (ex_imm),
    .ex_pc4       (ex_pc4),
    .ex_reg_write (ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_alu_src   (ex_alu_src),
    .ex_reg_dst   (ex_reg_dst),
    .ex_branch    (ex_branch),
    .ex_alu_op    (ex_alu_op),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign obs = {ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_reg_write,
                ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_branch,
                ex_alu_op};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rs/rt/rd, reg_write, mem_read; a load also sets mem_to_reg/alu_src, R-type sets reg_dst.
  function automatic stage_t ins(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic rw, input logic mr);
    stage_t s;
    s            = '0;
    s.rs         = rs;
    s.rt         = rt;
    s.rd         = rd;
    s.rdata1     = 32'h1000 + 32'(rs);
    s.rdata2     = 32'h2000 + 32'(rt);
    s.imm        = 32'hffff_fff0 + 32'(rd);
    s.pc4        = 32'h0040_0000 + {22'd0, rs, rd};
    s.reg_write  = rw;
    s.mem_read   = mr;
    s.mem_to_reg = mr;
    s.alu_src    = mr;
    s.reg_dst    = !mr;
    s.alu_op     = mr ? 2'b00 : 2'b10;
    return s;
  endfunction

  task automatic step(input stage_t in, input bit uses, input bit fl, input bit hd,
                      input int kind, input bit exp_pcw, input int exp_bub, input int exp_fl);
    reg_exp_t e;
    @(posedge clk);
    #2;
    rst_n      = 1'b1;
    id_s       = in;
    id_uses_rt = uses;
    ex_flush   = fl;
    hold       = hd;
    if (kind == KLOAD) cur = in;
    else if (kind == KBUB) cur = '0;
    e.st  = cur;
    e.bub = exp_bub;
    e.fl  = exp_fl;
    cq.push_back(exp_pcw);
    rq.push_back(e);
  endtask

  // Stall enables are combinational: check them mid-cycle, before the capturing edge.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("pc_write", 160'(pc_write), 160'(e));
        chk("if_id_write", 160'(if_id_write), 160'(e));
      end
    end
  end

  initial begin
    reg_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("ex_state", 160'(obs), 160'(e.st));
        chk("bubble_cnt", 160'(bubble_cnt), 160'(e.bub));
        chk("flush_cnt", 160'(flush_cnt), 160'(e.fl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] rnd;
    stage_t       lw8, add8, addrt8, pass, beq;
    int           b, f;
    rnd        = {$urandom, $urandom, $urandom, $urandom, $urandom};
    rst_n      = 1'b0;
    id_s       = rnd[151:0];
    id_uses_rt = 1'b1;
    ex_flush   = 1'b0;
    hold       = 1'b0;
    cur        = '0;
    #3;
    chk("reset_state", 160'(obs), 160'd0);
    chk("reset_pc_write", 160'(pc_write), 160'd1);
    chk("reset_bubble_cnt", 160'(bubble_cnt), 160'd0);
    chk("reset_flush_cnt", 160'(flush_cnt), 160'd0);

    lw8    = ins(5'd1, 5'd8, 5'd0, 1'b1, 1'b1);
    add8   = ins(5'd8, 5'd9, 5'd10, 1'b1, 1'b0);
    addrt8 = ins(5'd2, 5'd8, 5'd11, 1'b1, 1'b0);
    pass   = ins(5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
    pass.rdata1 = 32'h11;
    beq           = ins(5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
    beq.branch    = 1'b1;
    beq.reg_dst   = 1'b0;
    beq.alu_op    = 2'b01;
    beq.mem_write = 1'b1;

    step(pass, 1'b1, 1'b0, 1'b0, KLOAD, 1'b1, 0, 0);
    step(beq, 1'b1, 1'b0, 1'b0, KLOAD, 1'b1, 0, 0);
    // load-use on rs
    step(lw8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, 0, 0);
    step(add8, 1'b1, 1'b0, 1'b0, KBUB, 1'b0, 1, 0);
    step(add8, 1'b1, 1'b0, 1'b0, KLOAD, 1'b1, 1, 0);
    // load-use on rt
    step(lw8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, 1, 0);
    step(addrt8, 1'b1, 1'b0, 1'b0, KBUB, 1'b0, 2, 0);
    step(addrt8, 1'b1, 1'b0, 1'b0, KLOAD, 1'b1, 2, 0);
    // rt matches but is not a source
    step(lw8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, 2, 0);
    step(addrt8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, 2, 0);
    // load to $0 never stalls
    step(ins(5'd1, 5'd0, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, 2, 0);
    step(ins(5'd0, 5'd0, 5'd3, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, KLOAD, 1'b1, 2, 0);
    // flush together with load-use: flush counted, enables still stall
    step(lw8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, 2, 0);
    step(add8, 1'b1, 1'b1, 1'b0, KBUB, 1'b0, 2, 1);
    // hold with flush pending for three cycles, then hold drops
    step(lw8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, 2, 1);
    for (int i = 0; i < 3; i++) step(add8, 1'b1, 1'b1, 1'b1, KHOLD, 1'b0, 2, 1);
    step(add8, 1'b1, 1'b1, 1'b0, KBUB, 1'b0, 2, 2);

    b = 2;
    f = 2;
    for (int i = 0; i < 14; i++) begin
      step(lw8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, b, f);
      b = (b < 15) ? b + 1 : 15;
      step(add8, 1'b1, 1'b0, 1'b0, KBUB, 1'b0, b, f);
    end
    for (int i = 0; i < 14; i++) begin
      f = (f < 15) ? f + 1 : 15;
      step(pass, 1'b1, 1'b1, 1'b0, KBUB, 1'b1, b, f);
    end

    // async reset in the middle of a hold
    step(lw8, 1'b0, 1'b0, 1'b0, KLOAD, 1'b1, b, f);
    step(add8, 1'b1, 1'b0, 1'b1, KHOLD, 1'b0, b, f);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 160'(obs), 160'd0);
    chk("async_reset_pc_write", 160'(pc_write), 160'd1);
    chk("async_reset_bubble_cnt", 160'(bubble_cnt), 160'd0);
    chk("async_reset_flush_cnt", 160'(flush_cnt), 160'd0);
    cur = '0;
    step(add8, 1'b1, 1'b0, 1'b0, KLOAD, 1'b1, 0, 0);
    step(pass, 1'b1, 1'b0, 1'b0, KLOAD, 1'b1, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", 160'(rq.size() + cq.size()), 160'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
